// File: rtl/dmem_responder.sv
// Memory-side responder for the core load/store port: valid/ready request, programmable
// wait states, RV32I byte-lane load/store with sign/zero extension and an error flag.
module dmem_responder #(
  parameter int addlen   = 32,
  parameter int vlen     = 32,
  parameter int len      = 100,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [addlen-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [vlen-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [vlen-1:0]   resp_rdata,
  output logic              resp_err
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | counting down wait states, access on count 1
  // RESP  | response registered; resp_valid rises one cycle after the access
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int IW = (len > 1) ? $clog2(len) : 1;

  state_t              state;
  logic [3:0]          cnt;
  logic                we_q;
  logic [addlen-1:0]   addr_q;
  logic [2:0]          f3_q;
  logic [vlen-1:0]     wdata_q;
  logic [vlen-1:0]     mem [len];

  logic                a_we;
  logic [addlen-1:0]   a_addr;
  logic [2:0]          a_f3;
  logic [vlen-1:0]     a_wdata;
  logic [addlen-3:0]   word_idx;
  logic [1:0]          off;
  logic                in_range;
  logic                do_access;
  logic [vlen-1:0]     mem_word;
  logic [vlen-1:0]     wr_word;
  logic [vlen-1:0]     acc_rdata;
  logic                acc_err;
  logic [7:0]          b_lane;
  logic [15:0]         h_lane;
  logic                mem_we;

  // With zero wait states the access uses the live request fields.
  always_comb begin
    a_we      = (state == IDLE) ? req_we     : we_q;
    a_addr    = (state == IDLE) ? req_addr   : addr_q;
    a_f3      = (state == IDLE) ? req_funct3 : f3_q;
    a_wdata   = (state == IDLE) ? req_wdata  : wdata_q;
    word_idx  = a_addr[addlen-1:2];
    off       = a_addr[1:0];
    in_range  = word_idx < (addlen-2)'(len);
    do_access = ((state == IDLE) && req_valid && (WAIT_CYC == 0)) ||
                ((state == WAIT) && (cnt == 4'd1));
    mem_word  = in_range ? mem[word_idx[IW-1:0]] : '0;
  end

  always_comb begin
    acc_err   = 1'b0;
    acc_rdata = '0;
    wr_word   = mem_word;
    b_lane    = mem_word[{off, 3'b000} +: 8];
    h_lane    = off[1] ? mem_word[31:16] : mem_word[15:0];
    case (a_f3)
      3'b000: begin
        acc_rdata = {{24{b_lane[7]}}, b_lane};
        wr_word[{off, 3'b000} +: 8] = a_wdata[7:0];
      end
      3'b001: begin
        acc_err   = off[0];
        acc_rdata = {{16{h_lane[15]}}, h_lane};
        wr_word[{off[1], 4'b0000} +: 16] = a_wdata[15:0];
      end
      3'b010: begin
        acc_err   = (off != 2'b00);
        acc_rdata = mem_word;
        wr_word   = a_wdata;
      end
      3'b100: begin
        acc_err   = a_we;
        acc_rdata = {24'h0, b_lane};
      end
      3'b101: begin
        acc_err   = a_we | off[0];
        acc_rdata = {16'h0, h_lane};
      end
      default: acc_err = 1'b1;
    endcase
    if (!in_range) acc_err = 1'b1;
    if (acc_err || a_we) acc_rdata = '0;
  end

  // A store still pending when reset hits must not land in the array.
  assign mem_we = do_access && a_we && !acc_err && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx[IW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      f3_q       <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            f3_q      <= req_funct3;
            wdata_q   <= req_wdata;
            cnt       <= 4'(WAIT_CYC);
            req_ready <= 1'b0;
            if (do_access) begin
              state      <= RESP;
              resp_rdata <= acc_rdata;
              resp_err   <= acc_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (do_access) begin
            state      <= RESP;
            resp_rdata <= acc_rdata;
            resp_err   <= acc_err;
          end
        end
        RESP: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYC=2 instance and a WAIT_CYC=0 instance
// share one request bus; expected responses are queued at issue and popped on resp_valid.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic        sel;

  logic        rv_a, rv_b, rr_a, rr_b, err_a, err_b;
  logic [31:0] rd_a, rd_b;
  logic        rq_valid_a, rq_valid_b;
  logic        rv, rr, rerr;
  logic [31:0] rd;

  int          errors = 0;
  int          checks = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  assign rq_valid_a = req_valid & ~sel;
  assign rq_valid_b = req_valid & sel;
  assign rv   = sel ? rv_b  : rv_a;
  assign rr   = sel ? rr_b  : rr_a;
  assign rd   = sel ? rd_b  : rd_a;
  assign rerr = sel ? err_b : err_a;

  dmem_responder #(.addlen(32), .vlen(32), .len(100), .WAIT_CYC(2)) dut (
    .clk(clk), .reset(reset), .req_valid(rq_valid_a), .req_ready(rr_a),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(rv_a), .resp_ready(resp_ready), .resp_rdata(rd_a), .resp_err(err_a));

  dmem_responder #(.addlen(32), .vlen(32), .len(100), .WAIT_CYC(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(rq_valid_b), .req_ready(rr_b),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .resp_valid(rv_b), .resp_ready(resp_ready), .resp_rdata(rd_b), .resp_err(err_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee,
                      input int hold, input string tag);
    int n;
    logic [32:0] e;
    exp_q.push_back({ee, er});
    @(negedge clk);
    req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    req_valid = 1'b1;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_accept"}, {31'h0, rr}, 32'h0);
    n = 0;
    while (!rv && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, sel ? 32'd1 : 32'd3);
    e = exp_q.pop_front();
    chk({tag, "_rdata"}, rd, e[31:0]);
    chk({tag, "_err"}, {31'h0, rerr}, {31'h0, e[32]});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_we = 1'b1; req_addr = 32'h30; req_funct3 = 3'b010; req_wdata = 32'hBAD0BAD0;
        req_valid = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({tag, "_hold_valid"}, {31'h0, rv}, 32'h1);
      chk({tag, "_hold_rdata"}, rd, e[31:0]);
      chk({tag, "_hold_err"}, {31'h0, rerr}, {31'h0, e[32]});
      chk({tag, "_hold_ready"}, {31'h0, rr}, 32'h0);
    end
    if (hold != 0) begin
      @(negedge clk);
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_done_valid"}, {31'h0, rv}, 32'h0);
    chk({tag, "_done_ready"}, {31'h0, rr}, 32'h1);
    resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_funct3 = '0; req_wdata = '0; resp_ready = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, rr_a}, 32'h1);
    chk("rst_valid", {31'h0, rv_a}, 32'h0);
    chk("rst_rdata", rd_a, 32'h0);
    chk("rst_err", {31'h0, err_a}, 32'h0);
    reset = 1'b0;

    xact(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0, 0, "sw10");
    xact(1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, 0, "lw10");
    xact(1'b0, 32'h13, 3'b000, 32'h0,        32'hFFFFFFDE, 1'b0, 0, "lb13");
    xact(1'b0, 32'h13, 3'b100, 32'h0,        32'h000000DE, 1'b0, 0, "lbu13");
    xact(1'b0, 32'h12, 3'b001, 32'h0,        32'hFFFFDEAD, 1'b0, 0, "lh12");
    xact(1'b0, 32'h10, 3'b101, 32'h0,        32'h0000BEEF, 1'b0, 0, "lhu10");
    xact(1'b1, 32'h11, 3'b000, 32'h123456AA, 32'h0,        1'b0, 0, "sb11");
    xact(1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADAAEF, 1'b0, 0, "lw10_sb");
    xact(1'b1, 32'h12, 3'b001, 32'h0000CAFE, 32'h0,        1'b0, 0, "sh12");
    xact(1'b0, 32'h10, 3'b010, 32'h0,        32'hCAFEAAEF, 1'b0, 0, "lw10_sh");

    xact(1'b0, 32'h12,  3'b010, 32'h0,        32'h0, 1'b1, 0, "lw12_mis");
    xact(1'b0, 32'h11,  3'b001, 32'h0,        32'h0, 1'b1, 0, "lh11_mis");
    xact(1'b0, 32'h10,  3'b011, 32'h0,        32'h0, 1'b1, 0, "f3_011");
    xact(1'b1, 32'h10,  3'b100, 32'h11111111, 32'h0, 1'b1, 0, "sbu_ill");
    xact(1'b1, 32'h12,  3'b010, 32'h22222222, 32'h0, 1'b1, 0, "sw12_mis");
    xact(1'b1, 32'd400, 3'b010, 32'h33333333, 32'h0, 1'b1, 0, "sw400");
    xact(1'b0, 32'd400, 3'b010, 32'h0,        32'h0, 1'b1, 0, "lw400");
    xact(1'b1, 32'h0,   3'b010, 32'h0,        32'h0, 1'b0, 0, "sw0_clr");
    xact(1'b1, 32'h200, 3'b010, 32'h44444444, 32'h0, 1'b1, 0, "sw200");
    xact(1'b0, 32'h0,   3'b010, 32'h0,        32'h0, 1'b0, 0, "lw0_alias");
    xact(1'b0, 32'h10,  3'b010, 32'h0, 32'hCAFEAAEF, 1'b0, 0, "lw10_keep");

    xact(1'b1, 32'h30, 3'b010, 32'h0,        32'h0,        1'b0, 0, "sw30_clr");
    xact(1'b0, 32'h10, 3'b010, 32'h0,        32'hCAFEAAEF, 1'b0, 5, "lw10_hold");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_second_resp", {31'h0, rv}, 32'h0);
    end
    xact(1'b0, 32'h30, 3'b010, 32'h0, 32'h0, 1'b0, 0, "lw30_ignored");

    xact(1'b1, 32'h20, 3'b010, 32'h0, 32'h0, 1'b0, 0, "sw20_clr");
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", {31'h0, rv_a}, 32'h0);
    chk("rst_mid_ready", {31'h0, rr_a}, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    xact(1'b0, 32'h20, 3'b010, 32'h0, 32'h0, 1'b0, 0, "lw20_discard");
    xact(1'b0, 32'h10, 3'b010, 32'h0, 32'hCAFEAAEF, 1'b0, 0, "lw10_persist");

    sel = 1'b1;
    xact(1'b1, 32'h4, 3'b010, 32'h11223344, 32'h0,        1'b0, 0, "w0_sw4");
    xact(1'b0, 32'h4, 3'b010, 32'h0,        32'h11223344, 1'b0, 0, "w0_lw4");
    xact(1'b0, 32'h6, 3'b001, 32'h0,        32'h00001122, 1'b0, 0, "w0_lh6");
    xact(1'b0, 32'h5, 3'b000, 32'h0,        32'h00000033, 1'b0, 0, "w0_lb5");
    xact(1'b0, 32'h7, 3'b010, 32'h0,        32'h0,        1'b1, 0, "w0_lw7_mis");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
